// File: rtl/instruction_decoder_pipe_if.sv
// Handshake bundle for instruction_decoder_pipe: producer-side instruction
// stream and consumer-side decoded stream. DUT uses slave, bench uses master.
interface instruction_decoder_pipe_if #(
  parameter int INSTR_W = 8
);
  // Both streams use valid/ready: a transfer happens on a rising edge where
  // valid && ready; the sender holds valid and data stable until it happens.
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instruction;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         op_class;
  logic [INSTR_W-1:0] out_instr;

  modport slave (
    input  in_valid, instruction, out_ready,
    output in_ready, out_valid, op_class, out_instr
  );

  modport master (
    output in_valid, instruction, out_ready,
    input  in_ready, out_valid, op_class, out_instr
  );
endinterface

// File: rtl/instruction_decoder_pipe.sv
// Decodes instruction words into a class code and buffers them in a DEPTH-entry queue.
// Optional per-class saturating statistics counters are enabled by macro DEC_STATS_EN.
module instruction_decoder_pipe #(
  parameter int INSTR_W = 8,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  instruction_decoder_pipe_if.slave bus,
  output logic [$clog2(DEPTH):0]    level,
  input  logic [3:0]                stat_sel,
  output logic [CNT_W-1:0]          stat_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [AW-1:0]      rd_ptr, wr_ptr, head_idx;
  logic [3:0]         class_mem [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [2:0]         top_f, low_f;
  logic [3:0]         in_class;
  logic               push, pop;

  assign top_f = bus.instruction[INSTR_W-1 -: 3];
  assign low_f = bus.instruction[2:0];

  // A field value below 4 is exactly a clear top bit of that field.
  always_comb begin
    in_class = 4'd8;
    if (!top_f[2])      in_class = {2'b00, top_f[1:0]};
    else if (!low_f[2]) in_class = {2'b01, low_f[1:0]};
  end

  assign bus.in_ready  = (level != FULL_LVL) || bus.out_ready;
  assign bus.out_valid = (level != '0);
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // When empty, the slot just behind rd_ptr still holds the last popped entry.
  assign head_idx      = (level == '0) ? rd_ptr - 1'b1 : rd_ptr;
  assign bus.op_class  = class_mem[head_idx];
  assign bus.out_instr = instr_mem[head_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        class_mem[i] <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        class_mem[wr_ptr] <= in_class;
        instr_mem[wr_ptr] <= bus.instruction;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

`ifdef DEC_STATS_EN
  logic [CNT_W-1:0] cnt [9];
  logic [CNT_W-1:0] sel_val;

  always_comb begin
    sel_val = '0;
    for (int i = 0; i < 9; i++)
      if (stat_sel == 4'(i)) sel_val = cnt[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) cnt[i] <= '0;
      stat_count <= '0;
    end else begin
      for (int i = 0; i < 9; i++)
        if (push && in_class == 4'(i) && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
      stat_count <= sel_val;
    end
  end
`else
  logic stat_unused;
  assign stat_unused = ^stat_sel;
  assign stat_count  = '0;
`endif
endmodule

// File: tb/tb_instruction_decoder_pipe.sv
// Self-checking bench for instruction_decoder_pipe: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_instruction_decoder_pipe;
  localparam int INSTR_W = 8;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 2;
  localparam int AW      = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [AW:0]      level;
  logic [3:0]       stat_sel;
  logic [CNT_W-1:0] stat_count;

  int tests = 0;
  int fails = 0;

  instruction_decoder_pipe_if #(.INSTR_W(INSTR_W)) bus ();

  instruction_decoder_pipe #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .level(level),
    .stat_sel(stat_sel), .stat_count(stat_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  // reference model / scoreboard
  logic [INSTR_W-1:0] exp_q[$];
  logic [INSTR_W-1:0] last_instr;
  logic [3:0]         last_class;
  int                 sb_cnt[9];
  logic [CNT_W-1:0]   exp_stat;

  function automatic logic [3:0] decode_ref(input logic [INSTR_W-1:0] w);
    int t, l;
    t = int'(w) / (2 ** (INSTR_W - 3));
    l = int'(w) % 8;
    if (t < 4) return 4'(t);
    if (l < 4) return 4'(4 + l);
    return 4'd8;
  endfunction

  task automatic reset_model();
    exp_q.delete();
    last_instr = '0;
    last_class = '0;
    for (int i = 0; i < 9; i++) sb_cnt[i] = 0;
    exp_stat = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: one clock cycle of stimulus, checked against the model before the edge
  task automatic step(input logic v, input logic [INSTR_W-1:0] w, input logic ordy,
                      input logic [3:0] sel, output logic acc);
    logic exp_rdy, do_pop;
    logic [3:0] cls;
    @(negedge clk);
    bus.in_valid    = v;
    bus.instruction = w;
    bus.out_ready   = ordy;
    stat_sel        = sel;
    #1;
    exp_rdy = (exp_q.size() < DEPTH) || ordy;
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    check("level", 32'(level), 32'(exp_q.size()));
    if (exp_q.size() != 0) begin
      check("head_class", 32'(bus.op_class), 32'(decode_ref(exp_q[0])));
      check("head_instr", 32'(bus.out_instr), 32'(exp_q[0]));
    end else begin
      check("idle_class", 32'(bus.op_class), 32'(last_class));
      check("idle_instr", 32'(bus.out_instr), 32'(last_instr));
    end
    check("stat_count", 32'(stat_count), 32'(exp_stat));
    acc    = v && exp_rdy;
    do_pop = ordy && (exp_q.size() != 0);
    @(posedge clk);
`ifdef DEC_STATS_EN
    exp_stat = (sel < 9) ? CNT_W'(sb_cnt[sel]) : '0;
`else
    exp_stat = '0;
`endif
    if (do_pop) begin
      last_instr = exp_q.pop_front();
      last_class = decode_ref(last_instr);
    end
    if (acc) begin
      exp_q.push_back(w);
      cls = decode_ref(w);
      if (sb_cnt[cls] < 2 ** CNT_W - 1) sb_cnt[cls]++;
    end
  endtask

  logic [INSTR_W-1:0] words_a[4] = '{8'h00, 8'h3F, 8'h40, 8'h7F};
  logic [INSTR_W-1:0] words_b[5] = '{8'h80, 8'hF9, 8'hFA, 8'hFB, 8'hFF};

  initial begin
    logic acc;
    reset_model();
    bus.in_valid = 1'b0; bus.instruction = '0; bus.out_ready = 1'b0; stat_sel = '0;

    // reset state
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_op_class", 32'(bus.op_class), 32'd0);
    check("rst_out_instr", 32'(bus.out_instr), 32'd0);
    check("rst_stat", 32'(stat_count), 32'd0);
    #12 rst_n = 1'b1;

    // classes 0..3 and 4..8, one cycle latency into an empty queue
    for (int i = 0; i < 4; i++) begin
      step(1'b1, words_a[i], 1'b1, 4'd0, acc);
      check("push_a_acc", 32'(acc), 32'd1);
    end
    step(1'b0, '0, 1'b1, 4'd0, acc);
    for (int i = 0; i < 5; i++) step(1'b1, words_b[i], 1'b1, 4'd0, acc);
    step(1'b0, '0, 1'b1, 4'd0, acc);
    step(1'b0, '0, 1'b1, 4'd0, acc);

    // fill to DEPTH, hold the fifth word, then push and pop together while full
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 4'd0, acc);
    step(1'b1, 8'hC5, 1'b0, 4'd0, acc);
    check("full_hold_acc", 32'(acc), 32'd0);
    step(1'b1, 8'hC5, 1'b0, 4'd0, acc);
    check("full_hold_acc2", 32'(acc), 32'd0);
    step(1'b1, 8'hC5, 1'b1, 4'd0, acc);
    check("full_pushpop_acc", 32'(acc), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hE0 + i), 1'b1, 4'd0, acc);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 4'd0, acc);

    // asynchronous reset between edges with entries queued
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 4'd0, acc);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_level", 32'(level), 32'd0);
    check("async_in_ready", 32'(bus.in_ready), 32'd1);
    check("async_op_class", 32'(bus.op_class), 32'd0);
    #1 rst_n = 1'b1;
    reset_model();

    // statistics: five LOADs saturate a 2-bit counter, out-of-range select reads 0
    for (int i = 0; i < 5; i++) step(1'b1, 8'h00, 1'b1, 4'd0, acc);
    step(1'b0, '0, 1'b1, 4'd0, acc);
    step(1'b0, '0, 1'b1, 4'd0, acc);
    #1;
`ifdef DEC_STATS_EN
    check("stat_saturated", 32'(stat_count), 32'd3);
`else
    check("stat_disabled", 32'(stat_count), 32'd0);
`endif
    step(1'b0, '0, 1'b1, 4'd9, acc);
    step(1'b0, '0, 1'b1, 4'd9, acc);
    #1;
    check("stat_sel9", 32'(stat_count), 32'd0);

    // random traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), acc);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 4'd0, acc);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
